// File: rtl/step_rate_if.sv
// Bundle between the speed/keypad front end and the step-rate generator:
// requested motion on the way in, applied speed and coil drive on the way out.
interface step_rate_if;
  logic       enable;
  logic       dir;
  logic       half_step;
  logic [3:0] speed_value;
  logic [3:0] cur_speed;
  logic       step_pulse;
  logic [3:0] coils;
  logic       moving;
  logic [1:0] state_o;

  modport master (
    output enable, dir, half_step, speed_value,
    input  cur_speed, step_pulse, coils, moving, state_o
  );

  modport slave (
    input  enable, dir, half_step, speed_value,
    output cur_speed, step_pulse, coils, moving, state_o
  );
endinterface

// File: rtl/step_rate_gen.sv
// Stepper step-rate generator: ramped speed code -> phase-accumulator step strobe
// plus 4-wire coil pattern, with a forced stop before any direction reversal.
module step_rate_gen #(
  parameter int CLK_HZ         = 50000000,
  parameter int STEPS_PER_UNIT = 10,
  parameter int RAMP_CYCLES    = 5000000,
  parameter int ACC_W          = 32
) (
  input  logic      clk,
  input  logic      rst,
  step_rate_if.slave bus
);

  localparam int RAMP_W = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_REV  = 2'd2
  } state_t;

  function automatic logic [3:0] coil_pattern(input logic [2:0] idx);
    case (idx)
      3'd0:    coil_pattern = 4'b1000;
      3'd1:    coil_pattern = 4'b1100;
      3'd2:    coil_pattern = 4'b0100;
      3'd3:    coil_pattern = 4'b0110;
      3'd4:    coil_pattern = 4'b0010;
      3'd5:    coil_pattern = 4'b0011;
      3'd6:    coil_pattern = 4'b0001;
      default: coil_pattern = 4'b1001;
    endcase
  endfunction

  // Full-step only lands on odd (two-phase-on) entries; from an even index this
  // is a single move to the neighbouring odd entry in the travel direction.
  function automatic logic [2:0] next_index(input logic [2:0] idx, input logic half, input logic fwd);
    logic [2:0] stride;
    stride = (half || !idx[0]) ? 3'd1 : 3'd2;
    next_index = fwd ? (idx + stride) : (idx - stride);
  endfunction

  state_t            state_q, state_d;
  logic [3:0]        cur_speed_q, cur_speed_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [2:0]        idx_q, idx_d;
  logic              dir_q, dir_d;
  logic [RAMP_W-1:0] ramp_q, ramp_d;
  logic              step_q, step_d;
  logic [3:0]        coils_q, coils_d;
  logic              moving_q, moving_d;

  logic [3:0]        tgt_s;
  logic [3:0]        eff_tgt_s;
  logic              ramp_tick_s;
  logic [ACC_W-1:0]  inc_s;
  logic [ACC_W-1:0]  sum_s;

  always_comb begin
    tgt_s = (bus.speed_value > 4'd6) ? 4'd6 : bus.speed_value;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_STOP;
      dir_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
    end
  end

  // active_dir is only latched on leaving STOP, i.e. with the motor at rest
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    case (state_q)
      ST_STOP: begin
        if (bus.enable && (tgt_s != 4'd0)) begin
          dir_d   = bus.dir;
          state_d = ST_RUN;
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_RUN: begin
        if (bus.dir != dir_q) begin
          state_d = ST_REV;
        end else if ((cur_speed_q == 4'd0) && (eff_tgt_s == 4'd0)) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_REV: begin
        if (cur_speed_q == 4'd0) begin
          state_d = ST_STOP;
        end else if (bus.dir == dir_q) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_REV;
        end
      end
      default: begin
        state_d = ST_STOP;
      end
    endcase
  end

  always_comb begin
    if (!bus.enable || (state_q == ST_REV)) begin
      eff_tgt_s = 4'd0;
    end else begin
      eff_tgt_s = tgt_s;
    end
  end

  always_comb begin
    ramp_tick_s = (ramp_q == RAMP_W'(RAMP_CYCLES - 1));
    ramp_d      = ramp_tick_s ? '0 : (ramp_q + RAMP_W'(1));
    if (ramp_tick_s && (cur_speed_q < eff_tgt_s)) begin
      cur_speed_d = cur_speed_q + 4'd1;
    end else if (ramp_tick_s && (cur_speed_q > eff_tgt_s)) begin
      cur_speed_d = cur_speed_q - 4'd1;
    end else begin
      cur_speed_d = cur_speed_q;
    end
    moving_d = (cur_speed_d != 4'd0);
  end

  // Stepping uses the speed applied this cycle, so a same-cycle ramp tick
  // only affects the increment from the next cycle on.
  always_comb begin
    inc_s = ACC_W'(cur_speed_q) * ACC_W'(STEPS_PER_UNIT);
    sum_s = acc_q + inc_s;
    if (cur_speed_q == 4'd0) begin
      acc_d  = '0;
      step_d = 1'b0;
      idx_d  = idx_q;
    end else if (sum_s >= ACC_W'(CLK_HZ)) begin
      acc_d  = sum_s - ACC_W'(CLK_HZ);
      step_d = 1'b1;
      idx_d  = next_index(idx_q, bus.half_step, dir_q);
    end else begin
      acc_d  = sum_s;
      step_d = 1'b0;
      idx_d  = idx_q;
    end
    if (bus.enable || (cur_speed_q != 4'd0)) begin
      coils_d = coil_pattern(idx_d);
    end else begin
      coils_d = 4'b0000;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_speed_q <= 4'd0;
      acc_q       <= '0;
      idx_q       <= 3'd0;
      ramp_q      <= '0;
      step_q      <= 1'b0;
      coils_q     <= 4'b0000;
      moving_q    <= 1'b0;
    end else begin
      cur_speed_q <= cur_speed_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      ramp_q      <= ramp_d;
      step_q      <= step_d;
      coils_q     <= coils_d;
      moving_q    <= moving_d;
    end
  end

  assign bus.cur_speed  = cur_speed_q;
  assign bus.step_pulse = step_q;
  assign bus.coils      = coils_q;
  assign bus.moving     = moving_q;
  assign bus.state_o    = state_q;

endmodule

// File: tb/tb_step_rate_gen.sv
// Directed bench for step_rate_gen with a cycle-level behavioural model and
// hand-computed checkpoints (CLK_HZ=1000, STEPS_PER_UNIT=10, RAMP_CYCLES=8).
module tb_step_rate_gen;
  localparam int CLK_HZ = 1000;
  localparam int SPU    = 10;
  localparam int RC     = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   cmp_on = 1'b0;
  int   nchecks = 0;
  int   nerrs = 0;

  step_rate_if bus();

  step_rate_gen #(.CLK_HZ(CLK_HZ), .STEPS_PER_UNIT(SPU), .RAMP_CYCLES(RC), .ACC_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [3:0] tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};

  int m_speed = 0, m_acc = 0, m_idx = 0, m_dir = 1, m_state = 0, m_ramp = 0;
  int m_pulse = 0, m_coils = 0, m_moving = 0;
  logic [3:0] pc [$];

  task automatic check(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerrs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Next table position in the travel direction; full-step skips to the next odd entry
  function automatic int adv(input int idx, input int half, input int fwd);
    int d;
    int n;
    d = fwd ? 1 : 7;
    n = (idx + d) % 8;
    if (half == 0) begin
      while (n % 2 == 0) n = (n + d) % 8;
    end
    return n;
  endfunction

  function automatic int pos_of(input logic [3:0] c);
    for (int i = 0; i < 8; i++) if (tbl[i] == c) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_speed = 0; m_acc = 0; m_idx = 0; m_dir = 1; m_state = 0; m_ramp = 0;
    m_pulse = 0; m_coils = 0; m_moving = 0;
  endtask

  task automatic model_step();
    int tgt, eff, n_speed, n_acc, n_idx, n_dir, n_state, n_pulse;
    tgt = (int'(bus.speed_value) > 6) ? 6 : int'(bus.speed_value);
    eff = (!bus.enable || m_state == 2) ? 0 : tgt;
    n_speed = m_speed;
    if (m_ramp == RC - 1) begin
      if (n_speed < eff) n_speed++;
      else if (n_speed > eff) n_speed--;
    end
    n_acc = 0; n_pulse = 0; n_idx = m_idx;
    if (m_speed != 0) begin
      n_acc = m_acc + m_speed * SPU;
      if (n_acc >= CLK_HZ) begin
        n_acc -= CLK_HZ;
        n_pulse = 1;
        n_idx = adv(m_idx, int'(bus.half_step), m_dir);
      end
    end
    n_dir = m_dir; n_state = m_state;
    case (m_state)
      0: if (bus.enable && tgt != 0) begin n_state = 1; n_dir = int'(bus.dir); end
      1: if (int'(bus.dir) != m_dir) n_state = 2; else if (m_speed == 0 && eff == 0) n_state = 0;
      default: if (m_speed == 0) n_state = 0; else if (int'(bus.dir) == m_dir) n_state = 1;
    endcase
    m_coils  = (bus.enable || m_speed != 0) ? int'(tbl[n_idx]) : 0;
    m_speed  = n_speed; m_acc = n_acc; m_idx = n_idx; m_dir = n_dir; m_state = n_state;
    m_pulse  = n_pulse; m_moving = (n_speed != 0) ? 1 : 0;
    m_ramp   = (m_ramp + 1) % RC;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        check("cur_speed", int'(bus.cur_speed), m_speed);
        check("step_pulse", int'(bus.step_pulse), m_pulse);
        check("coils", int'(bus.coils), m_coils);
        check("moving", int'(bus.moving), m_moving);
        check("state", int'(bus.state_o), m_state);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_speed(input int v, input int bound, output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (int'(bus.cur_speed) != v && n < bound);
  endtask

  task automatic count_pulses(input int ncyc, output int cnt);
    cnt = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (bus.step_pulse) begin cnt++; pc.push_back(bus.coils); end
    end
  endtask

  task automatic next_pulse(input int bound, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.step_pulse && n < bound);
    if (bus.step_pulse) pc.push_back(bus.coils);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    logic [3:0] exp_fs [6];
    exp_fs = '{4'b1100, 4'b0110, 4'b0011, 4'b1001, 4'b1100, 4'b0110};
    bus.enable = 1'b1; bus.dir = 1'b1; bus.half_step = 1'b0; bus.speed_value = 4'd3;
    #1 rst = 1'b1;
    cmp_on = 1'b1;
    cyc(3);
    check("rst_speed", int'(bus.cur_speed), 0);
    check("rst_coils", int'(bus.coils), 0);
    check("rst_pulse", int'(bus.step_pulse), 0);
    check("rst_state", int'(bus.state_o), 0);
    check("rst_moving", int'(bus.moving), 0);
    rst = 1'b0;

    // Ramp 1,2,3 on 8-cycle ticks, then 3 steps per 100 cycles in full-step order
    for (int v = 1; v <= 3; v++) begin
      wait_speed(v, 20, n);
      check("ramp_up_interval", n, 8);
    end
    pc.delete();
    count_pulses(100, cnt);
    check("speed3_pulses_a", cnt, 3);
    count_pulses(100, cnt);
    check("speed3_pulses_b", cnt, 3);
    check("speed3_pulse_count", pc.size(), 6);
    for (int k = 0; k < 6 && k < pc.size(); k++) check("fullstep_coils", int'(pc[k]), int'(exp_fs[k]));

    // Half-step at speed 1: one step per 100 cycles walking all 8 entries
    bus.half_step = 1'b1; bus.speed_value = 4'd1;
    wait_speed(1, 40, n);
    check("slow_to_1", int'(bus.cur_speed), 1);
    pc.delete();
    next_pulse(200, n);
    for (int k = 0; k < 9; k++) begin
      next_pulse(150, n);
      check("half_interval", n, 100);
    end
    for (int k = 0; k + 1 < pc.size(); k++)
      check("half_walk", pos_of(pc[k+1]), (pos_of(pc[k]) + 1) % 8);

    // Clamp at 6, then ramp down to a stop holding the last pattern
    bus.half_step = 1'b0; bus.speed_value = 4'd9;
    wait_speed(6, 80, n);
    check("clamp_6", int'(bus.cur_speed), 6);
    count_pulses(100, cnt);
    check("speed6_pulses", cnt, 6);
    bus.speed_value = 4'd0;
    wait_speed(5, 10, n);
    check("down_to_5", int'(bus.cur_speed), 5);
    for (int v = 4; v >= 0; v--) begin
      wait_speed(v, 12, n);
      check("ramp_down_interval", n, 8);
    end
    cyc(1);
    check("stop_state", int'(bus.state_o), 0);
    check("stop_moving", int'(bus.moving), 0);
    check("stop_coils_held", int'(bus.coils != 4'b0000), 1);

    // Reversal at 4: decelerate to 0, STOP, RUN backwards, back up to 4
    bus.speed_value = 4'd4;
    wait_speed(4, 60, n);
    check("run_to_4", int'(bus.cur_speed), 4);
    bus.dir = 1'b0;
    cyc(1);
    check("rev_state", int'(bus.state_o), 2);
    for (int v = 3; v >= 0; v--) begin
      wait_speed(v, 12, n);
      check("rev_ramp_interval", n, (v == 3) ? 7 : 8);
    end
    cyc(1);
    check("rev_stop", int'(bus.state_o), 0);
    cyc(1);
    check("rev_run", int'(bus.state_o), 1);
    wait_speed(4, 50, n);
    check("rev_back_to_4", int'(bus.cur_speed), 4);

    // Aborted reversal: direction restored at speed 2, climbs back without reversing
    bus.dir = 1'b1;
    cyc(1);
    check("abort_rev_state", int'(bus.state_o), 2);
    wait_speed(2, 30, n);
    check("abort_at_2", int'(bus.cur_speed), 2);
    bus.dir = 1'b0;
    cyc(1);
    check("abort_run_state", int'(bus.state_o), 1);
    wait_speed(4, 30, n);
    check("abort_back_to_4", int'(bus.cur_speed), 4);

    // Disable at speed 2: ramp 1,0 then de-energize one cycle later
    bus.speed_value = 4'd2;
    wait_speed(2, 30, n);
    check("dis_at_2", int'(bus.cur_speed), 2);
    bus.enable = 1'b0;
    wait_speed(1, 12, n);
    check("dis_to_1", n, 8);
    wait_speed(0, 12, n);
    check("dis_to_0", n, 8);
    check("dis_coils_still_on", int'(bus.coils != 4'b0000), 1);
    cyc(1);
    check("dis_coils_off", int'(bus.coils), 0);
    check("dis_state", int'(bus.state_o), 0);
    check("dis_moving", int'(bus.moving), 0);

    // Asynchronous reset mid-run, then first tick 8 cycles after release
    bus.enable = 1'b1; bus.speed_value = 4'd3;
    wait_speed(2, 40, n);
    check("pre_rst_speed", int'(bus.cur_speed), 2);
    cyc(3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_speed", int'(bus.cur_speed), 0);
    check("arst_coils", int'(bus.coils), 0);
    check("arst_pulse", int'(bus.step_pulse), 0);
    check("arst_state", int'(bus.state_o), 0);
    cyc(2);
    rst = 1'b0;
    wait_speed(1, 20, n);
    check("post_rst_first_tick", n, 8);
    cyc(4);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end
endmodule
